uart_byte_rx: RTL
=================

// Module: uart_byte_rx
// PURPOSE
//  8N1 UART receiver for the BLE link. Oversamples the asynchronous RX line, frames
//  start/data/stop bits and presents each byte with a sticky ready flag.
//  Sits directly upstream of the rider-authorisation FSM, which reads rx_data on rdy
//  and acknowledges it with a one-cycle clr_rdy.
// PARAMETERS
//  BAUD_CNT  5208  clocks per bit (50 MHz / 9600 baud); must be >= 8
//  HALF_CNT  BAUD_CNT/2  clocks from start-edge detect to start-bit mid-sample
// PORTS
//  clk      in   1  system clock, all logic on posedge
//  rst      in   1  reset, asynchronous, active-high; clears all state
//  RX       in   1  asynchronous serial input, idle high
//  clr_rdy  in   1  one-cycle acknowledge from consumer; clears rdy and frm_err
//  rx_data  out  8  last correctly framed byte, LSB received first
//  rdy      out  1  sticky: a new valid byte is in rx_data
//  frm_err  out  1  sticky: last frame had stop bit = 0
// BEHAVIOUR
//  Reset values
//  - rx_data=8'h00, rdy=0, frm_err=0, state=IDLE.
//  - Both RX synchroniser flops preset to 1, so reset never looks like a start bit.
//  Synchroniser
//  - RX passes through 2 flops -> rx_s; the FSM sees only rx_s.
//  - A change on RX reaches rx_s 2 clocks later.
//  FSM: IDLE, START, DATA, STOP. One down-counter (width clog2(BAUD_CNT)+1) and a
//  4-bit bit index.
//  - IDLE: rx_s==0 at cycle T0 -> START, load counter with HALF_CNT.
//  - START: at counter==0 (T0+HALF_CNT), sample rx_s.
//      rx_s==1 -> false start; return to IDLE, no flag changes.
//      rx_s==0 -> DATA, reload BAUD_CNT, bit index=0.
//  - DATA: at each counter expiry, shift rx_s into bit 7 of the shift register
//    (right shift) and reload.
//      Data bit k (0..7) is sampled at T0+HALF_CNT+(k+1)*BAUD_CNT.
//      After bit 7 -> STOP.
//  - STOP: sample at T0+HALF_CNT+9*BAUD_CNT.
//      rx_s==1 -> rx_data<=shift reg, rdy<=1, frm_err<=0.
//      rx_s==0 -> frm_err<=1; rdy and rx_data unchanged.
//      Either way -> IDLE in the same cycle as the sample (no wait for the full stop
//      bit), so a back-to-back start edge is caught.
//  Latency
//  - rdy/frm_err update 1 clock after the stop sample.
//  - Relative to the RX falling edge: 2 + HALF_CNT + 9*BAUD_CNT + 1 clocks.
//  Boundary rules
//  - clr_rdy in the same cycle as a rdy/frm_err set: the set wins.
//  - clr_rdy while rdy=0: no effect; it never disturbs a byte in flight.
//  - New byte completes while rdy=1 (consumer slow): rx_data is overwritten and rdy
//    stays 1. No overrun flag; consumers must acknowledge within one frame.
//  - rx_data changes only on a valid stop; it is stable while rdy=1 until the next
//    valid frame.
//  - RX held low (break): start valid, data=0x00, stop=0 -> frm_err.
//      FSM then waits in IDLE until rx_s==1 before arming a new start.
//      Implement with an armed bit set on rx_s==1.
//  - rst asserted mid-frame: immediate return to the reset values; the partial byte
//    is discarded.
//  - Counters never wrap: each reload happens at ==0.
// TESTING (BAUD_CNT=16, HALF_CNT=8)
//  1. Send 0x47 ('G'), stop=1 -> rdy=1 at edge+2+8+144+1 clocks; rx_data=0x47;
//     frm_err=0.
//  2. 0x47 then immediate 0x53, no clr_rdy -> rdy remains 1; rx_data=0x53 after the
//     second stop; no byte lost to framing.
//  3. RX low pulse of 4 clocks in IDLE -> false start; rdy=0, rx_data unchanged;
//     a following 0x53 is received correctly.
//  4. Frame 0xA5 with stop=0 -> frm_err=1, rdy=0, rx_data keeps the prior value;
//     clr_rdy -> frm_err=0.
//  5. Assert rst during data bit 4 of 0x47 -> outputs 0 immediately; release, send
//     0x53 -> rx_data=0x53, rdy=1.
//  6. clr_rdy pulsed in the exact cycle rdy sets -> rdy=1; pulse one cycle later ->
//     rdy=0, rx_data held.

Source files
------------

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver: two-flop RX synchroniser, mid-bit sampling FSM and a
// sticky ready / framing-error pair acknowledged by a one-cycle clr_rdy.
module uart_byte_rx #(
   parameter int BAUD_CNT = 5208,
   parameter int HALF_CNT = BAUD_CNT / 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       RX,
   input  logic       clr_rdy,
   output logic [7:0] rx_data,
   output logic       rdy,
   output logic       frm_err
);

   localparam int CW = $clog2(BAUD_CNT) + 1;
   // Loaded one short because the cycle that reads zero is itself the sample cycle.
   localparam logic [CW-1:0] C_HALF = CW'(HALF_CNT - 1);
   localparam logic [CW-1:0] C_BAUD = CW'(BAUD_CNT - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t          r_state, w_state;
   logic [CW-1:0]   r_cnt, w_cnt;
   logic [3:0]      r_bit_idx, w_bit_idx;
   logic [7:0]      r_shift, w_shift;
   logic [7:0]      r_data, w_data;
   logic            r_rdy, w_rdy;
   logic            r_err, w_err;
   logic            r_armed, w_armed;
   logic            r_rx_m, r_rx_s;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rx_m    <= 1'b1;
         r_rx_s    <= 1'b1;
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_data    <= '0;
         r_rdy     <= 1'b0;
         r_err     <= 1'b0;
         r_armed   <= 1'b1;
      end else begin
         r_rx_m    <= RX;
         r_rx_s    <= r_rx_m;
         r_state   <= w_state;
         r_cnt     <= w_cnt;
         r_bit_idx <= w_bit_idx;
         r_shift   <= w_shift;
         r_data    <= w_data;
         r_rdy     <= w_rdy;
         r_err     <= w_err;
         r_armed   <= w_armed;
      end
   end

   always_comb begin
      w_state   = r_state;
      w_cnt     = (r_cnt != '0) ? r_cnt - CW'(1) : r_cnt;
      w_bit_idx = r_bit_idx;
      w_shift   = r_shift;
      w_data    = r_data;
      w_rdy     = r_rdy;
      w_err     = r_err;
      w_armed   = r_armed;

      // Acknowledge first so that a flag set later in this block wins.
      if (clr_rdy) begin
         w_rdy = 1'b0;
         w_err = 1'b0;
      end

      case (r_state)
         S_IDLE: begin
            if (!r_armed) begin
               if (r_rx_s) w_armed = 1'b1;
            end else if (!r_rx_s) begin
               w_state = S_START;
               w_cnt   = C_HALF;
            end
         end
         S_START: begin
            if (r_cnt == '0) begin
               if (r_rx_s) begin
                  w_state = S_IDLE;
               end else begin
                  w_state   = S_DATA;
                  w_cnt     = C_BAUD;
                  w_bit_idx = 4'd0;
               end
            end
         end
         S_DATA: begin
            if (r_cnt == '0) begin
               w_shift = {r_rx_s, r_shift[7:1]};
               w_cnt   = C_BAUD;
               if (r_bit_idx == 4'd7) w_state = S_STOP;
               else                   w_bit_idx = r_bit_idx + 4'd1;
            end
         end
         S_STOP: begin
            if (r_cnt == '0) begin
               w_state = S_IDLE;
               if (r_rx_s) begin
                  w_data  = r_shift;
                  w_rdy   = 1'b1;
                  w_err   = 1'b0;
                  w_armed = 1'b1;
               end else begin
                  // Line may be held in break; wait for idle-high before re-arming.
                  w_err   = 1'b1;
                  w_armed = 1'b0;
               end
            end
         end
         default: w_state = S_IDLE;
      endcase
   end

   assign rx_data = r_data;
   assign rdy     = r_rdy;
   assign frm_err = r_err;

endmodule
